symfir_mac_engine: RTL and testbench

SYMFIR_MAC_ENGINE -- requirements
Module: symfir_mac_engine

---
 rtl/symfir_pkg.sv | 45 ++++
 rtl/symfir_preadd_mult.sv | 60 ++++++
 rtl/symfir_mac_engine.sv | 186 ++++++++++++++++++
 tb/tb_symfir_mac_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/symfir_pkg.sv
// symfir_pkg
// Shared definitions for the symmetric FIR MAC engine: default geometry
// (tap count, sample width, coefficient width), the half-length coefficient
// array type with its default contents, the controller state encoding and a
// helper that sizes the accumulator so no partial sum can overflow.
package symfir_pkg;

  // Default geometry: 102 taps folded into 51 symmetric pairs, 24-bit
  // samples and 18-bit Q1.17 coefficients.
  localparam int NTAP_DEFAULT  = 102;
  localparam int DW_DEFAULT    = 24;
  localparam int CW_DEFAULT    = 18;
  localparam int NPAIR_DEFAULT = NTAP_DEFAULT / 2;

  // One coefficient per symmetric tap pair; entry k multiplies the sum
  // taps[k] + taps[NTAP-1-k].
  typedef logic signed [CW_DEFAULT-1:0] coeff_arr_t [0:NPAIR_DEFAULT-1];

  // Default coefficient set. A handful of distinct values at pairs 0, 10,
  // 25 and 50 make each pair position observable from an impulse on a
  // single tap; every other pair carries a small constant weight.
  localparam coeff_arr_t COEFF_DEFAULT = '{
    0:       18'sh01000,
    10:      18'sh02000,
    25:      18'sh04000,
    50:      18'sh00800,
    default: 18'sh00100
  };

  // Controller states: wait for a strobe, issue one pair per cycle, add the
  // last outstanding product, then round/saturate into the output register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    ROUND = 2'd3
  } state_e;

  // Accumulator width: full product width (DW+1 pre-add times CW) plus
  // enough guard bits to add NTAP/2 worst-case products without overflow.
  function automatic int acc_width(input int ntap, input int dw, input int cw);
    return dw + cw + 1 + $clog2(ntap / 2);
  endfunction

endpackage

// File: rtl/symfir_preadd_mult.sv
// symfir_preadd_mult
// Pre-add / multiply / product-register stage of the symmetric FIR. The two
// mirror-image taps are summed at DW+1 bits (so the sum never wraps), the sum
// is multiplied by the pair coefficient at full DW+CW+1 precision, and the
// product is registered when en_i is high. The register holds otherwise.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-low reset, clears the product register
//   en_i     : issue strobe, load a new product this cycle
//   tap_a_i  : newer tap of the pair (signed DW)
//   tap_b_i  : mirror tap of the pair (signed DW)
//   coeff_i  : pair coefficient (signed CW)
//   prod_o   : registered product (signed DW+CW+1)
module symfir_preadd_mult #(
  parameter int DW = 24,
  parameter int CW = 18
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DW-1:0]       tap_a_i,
  input  logic [DW-1:0]       tap_b_i,
  input  logic [CW-1:0]       coeff_i,
  output logic [DW+CW:0]      prod_o
);

  localparam int PW = DW + CW + 1;

  logic signed [DW:0]   pre_sum;
  logic signed [PW-1:0] pre_ext;
  logic signed [PW-1:0] coeff_ext;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_q;

  // Pre-add and multiply. Both operands are sign-extended to the full
  // product width first; since the true product fits in PW bits, the
  // truncated PW-bit multiply result is exact.
  always_comb begin
    pre_sum   = $signed({tap_a_i[DW-1], tap_a_i}) + $signed({tap_b_i[DW-1], tap_b_i});
    pre_ext   = {{(PW-DW-1){pre_sum[DW]}}, pre_sum};
    coeff_ext = {{(PW-CW){coeff_i[CW-1]}}, coeff_i};
    prod_d    = prod_q;
    if (en_i) begin
      prod_d = pre_ext * coeff_ext;
    end
  end

  // Product register, one pipeline stage between multiplier and accumulator.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/symfir_mac_engine.sv
// symfir_mac_engine
// Time-multiplexed symmetric FIR. On each sample strobe it walks the NTAP/2
// mirror tap pairs, one per cycle, through a pre-add/multiply stage and sums
// the products in a full-precision accumulator. The sum is then rounded from
// Q1.17 scaling back to sample scaling, saturated to DW bits and presented
// on y with a one-cycle y_valid. Result appears NTAP/2+2 edges after the
// strobe edge. The taps are read live from the delay line and must stay
// stable until the result is produced.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   sample_valid : delay line advanced, start a new output sample
//   taps         : delay-line taps, taps[0] newest (signed DW each)
//   y            : filtered output sample (signed DW), held between results
//   y_valid      : one-cycle strobe, y updated
//   busy         : computation in flight (ACC, DRAIN, ROUND)
//   overrun      : sticky, a strobe arrived while busy (cleared by reset only)
module symfir_mac_engine
  import symfir_pkg::*;
#(
  parameter int NTAP = NTAP_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int CW   = CW_DEFAULT,
  parameter logic signed [CW-1:0] COEFF [0:NTAP/2-1] = COEFF_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [DW-1:0] taps [0:NTAP-1],
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int NPAIR = NTAP / 2;
  localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int IW    = $clog2(NTAP);
  localparam int PW    = DW + CW + 1;
  localparam int AW    = acc_width(NTAP, DW, CW);

  localparam logic [KW-1:0] K_LAST = KW'(NPAIR - 1);

  // Half an output LSB at accumulator scale: the product carries CW-1
  // fractional bits from the coefficient, so half of 2^(CW-1) is 2^(CW-2).
  localparam logic signed [AW-1:0] RND_BIAS = {{(AW-1){1'b0}}, 1'b1} << (CW - 2);

  // Output saturation limits expressed at accumulator width.
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 overrun_q, overrun_d;

  logic                 issue;
  logic [IW-1:0]        mirror_idx;
  logic [DW-1:0]        tap_a;
  logic [DW-1:0]        tap_b;
  logic [CW-1:0]        coeff_k;
  logic [PW-1:0]        prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] shifted;
  logic [DW-1:0]        y_sat;

  // Pair selection: pair k combines the k-th newest tap with its mirror at
  // the far end of the delay line and uses the k-th half-length coefficient.
  always_comb begin
    mirror_idx = IW'(NTAP - 1) - IW'(k_q);
    tap_a      = taps[k_q];
    tap_b      = taps[mirror_idx];
    coeff_k    = COEFF[k_q];
  end

  symfir_preadd_mult #(
    .DW (DW),
    .CW (CW)
  ) u_preadd_mult (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (issue),
    .tap_a_i (tap_a),
    .tap_b_i (tap_b),
    .coeff_i (coeff_k),
    .prod_o  (prod)
  );

  // Round half up, drop the coefficient fraction bits, then clamp to the
  // DW-bit output range. This works on the current accumulator value and is
  // only registered into y while in ROUND.
  always_comb begin
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    rounded  = acc_q + RND_BIAS;
    shifted  = rounded >>> (CW - 1);
    if (shifted > Y_MAX) begin
      y_sat = Y_MAX[DW-1:0];
    end else if (shifted < Y_MIN) begin
      y_sat = Y_MIN[DW-1:0];
    end else begin
      y_sat = shifted[DW-1:0];
    end
  end

  // Controller next-state logic. The product register lags the issue by one
  // cycle, so in ACC the accumulator only adds once at least one pair has
  // been issued (k != 0), and DRAIN picks up the final pair's product.
  // A strobe while not idle is dropped and only latches the overrun flag.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q;
    issue     = 1'b0;

    if (sample_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        issue = 1'b1;
        if (k_q != '0) begin
          acc_d = acc_q + prod_ext;
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = ROUND;
      end
      ROUND: begin
        y_d       = y_sat;
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over everything, including a
  // strobe arriving in the same cycle, and discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_symfir_mac_engine.sv
// tb_symfir_mac_engine
// Scoreboard bench for symfir_mac_engine. Two instances share the tap array:
// one with the default coefficients for functional vectors, one with every
// coefficient at 18'h1FFFF for the saturation vectors. Stimulus pushes the
// hand-computed expected y into a per-instance queue; a monitor per instance
// pops and compares whenever y_valid is seen.
module tb_symfir_mac_engine;

  localparam int NTAP = 102;
  localparam int DW   = 24;
  localparam int LAT  = NTAP / 2 + 2;

  localparam logic [17:0] SAT_COEFF [0:NTAP/2-1] = '{default: 18'h1FFFF};

  logic          clk = 1'b0;
  logic          rst;
  logic          svMain;
  logic          svSat;
  logic [DW-1:0] taps [0:NTAP-1];
  logic [DW-1:0] yMain, ySat;
  logic          yvMain, yvSat;
  logic          busyMain, busySat;
  logic          ovMain, ovSat;

  int            testsRun    = 0;
  int            testsFailed = 0;
  logic [DW-1:0] expMainQ [$];
  logic [DW-1:0] expSatQ [$];
  logic [DW-1:0] expMain, expSat;

  always #5 clk = ~clk;

  symfir_mac_engine dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (svMain),
    .taps         (taps),
    .y            (yMain),
    .y_valid      (yvMain),
    .busy         (busyMain),
    .overrun      (ovMain)
  );

  symfir_mac_engine #(
    .COEFF (SAT_COEFF)
  ) dutSat (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (svSat),
    .taps         (taps),
    .y            (ySat),
    .y_valid      (yvSat),
    .busy         (busySat),
    .overrun      (ovSat)
  );

  // Monitor for the default-coefficient instance: every y_valid must match
  // the oldest outstanding expectation, and none may arrive unannounced.
  always @(negedge clk) begin
    if (rst && yvMain) begin
      testsRun++;
      if (expMainQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL main_unexpected_y_valid: got y=%h, required no y_valid", yMain);
      end else begin
        expMain = expMainQ.pop_front();
        if (yMain !== expMain) begin
          testsFailed++;
          $display("[TB] FAIL main_y: got %h, required %h", yMain, expMain);
        end
      end
    end
  end

  // Monitor for the saturation instance.
  always @(negedge clk) begin
    if (rst && yvSat) begin
      testsRun++;
      if (expSatQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL sat_unexpected_y_valid: got y=%h, required no y_valid", ySat);
      end else begin
        expSat = expSatQ.pop_front();
        if (ySat !== expSat) begin
          testsFailed++;
          $display("[TB] FAIL sat_y: got %h, required %h", ySat, expSat);
        end
      end
    end
  end

  // Single immediate comparison used by the stimulus thread.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clearTaps();
    for (int i = 0; i < NTAP; i++) taps[i] = '0;
  endtask

  task automatic setAllTaps(input logic [DW-1:0] v);
    for (int i = 0; i < NTAP; i++) taps[i] = v;
  endtask

  // Issue a one-cycle strobe to one instance, optionally registering the
  // expected result. Called #1 after a rising edge; returns #1 after the
  // edge that sampled the strobe.
  task automatic applyStimulus(input bit sat, input logic [DW-1:0] expY, input bit push);
    if (push) begin
      if (sat) expSatQ.push_back(expY);
      else     expMainQ.push_back(expY);
    end
    if (sat) svSat = 1'b1;
    else     svMain = 1'b1;
    @(posedge clk);
    #1;
    svSat  = 1'b0;
    svMain = 1'b0;
  endtask

  // Follow a computation from edge startCnt to y_valid: busy must stay high,
  // y must hold its previous value mid-flight, and y_valid must land exactly
  // LAT edges after the strobe edge. Returns #1 after that edge.
  task automatic checkOutput(input bit sat, input int startCnt, input logic [DW-1:0] holdY);
    int cnt;
    bit done;
    bit busyOk;
    cnt    = startCnt;
    done   = 1'b0;
    busyOk = 1'b1;
    check("busy_after_strobe", 32'(sat ? busySat : busyMain), 32'd1);
    while (!done && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (sat ? yvSat : yvMain) done = 1'b1;
      else if (!(sat ? busySat : busyMain)) busyOk = 1'b0;
      if (cnt == 20) check("y_hold", 32'(sat ? ySat : yMain), 32'(holdY));
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL y_valid_timeout: got no y_valid after %0d edges, required %0d", cnt, LAT);
    end else begin
      check("latency", 32'(cnt), 32'(LAT));
      check("busy_while_computing", 32'(busyOk), 32'd1);
      check("busy_low_in_y_valid_cycle", 32'(sat ? busySat : busyMain), 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    svMain = 1'b0;
    svSat  = 1'b0;
    clearTaps();
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", 32'(yMain), 32'd0);
    check("reset_y_valid", 32'(yvMain), 32'd0);
    check("reset_busy", 32'(busyMain), 32'd0);
    check("reset_overrun", 32'(ovMain), 32'd0);
    check("reset_sat_y", 32'(ySat), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero input.
    applyStimulus(1'b0, 24'h000000, 1'b1);
    checkOutput(1'b0, 0, 24'h000000);

    // The following strobes each land in the y_valid cycle of the previous
    // result, exercising back-to-back acceptance.
    // Impulse on the newest tap: 2^17 * 2^12 >> 17 = 0x1000.
    taps[0] = 24'h020000;
    applyStimulus(1'b0, 24'h001000, 1'b1);
    checkOutput(1'b0, 0, 24'h000000);

    // Mirror tap gives the same pair 0 result.
    clearTaps();
    taps[101] = 24'h020000;
    applyStimulus(1'b0, 24'h001000, 1'b1);
    checkOutput(1'b0, 0, 24'h001000);

    // Centre pair: (0x10000 + 0x10000) * 0x800 >> 17 = 0x800.
    clearTaps();
    taps[50] = 24'h010000;
    taps[51] = 24'h010000;
    applyStimulus(1'b0, 24'h000800, 1'b1);
    checkOutput(1'b0, 0, 24'h001000);

    // Pair 10: 0x1000 * 0x2000 = 2^25, >> 17 = 0x100.
    clearTaps();
    taps[10] = 24'h001000;
    applyStimulus(1'b0, 24'h000100, 1'b1);
    checkOutput(1'b0, 0, 24'h000800);

    // Negative sample on pair 25: -2^17 * 2^14 = -2^31, >> 17 = -2^14.
    clearTaps();
    taps[25] = 24'hFE0000;
    applyStimulus(1'b0, 24'hFFC000, 1'b1);
    checkOutput(1'b0, 0, 24'h000100);

    // Rounding boundary on pair 20 (coefficient 0x100): exactly half an LSB
    // rounds up to 1, just under half rounds down to 0.
    clearTaps();
    taps[20] = 24'h000100;
    applyStimulus(1'b0, 24'h000001, 1'b1);
    checkOutput(1'b0, 0, 24'hFFC000);
    taps[20] = 24'h0000FF;
    applyStimulus(1'b0, 24'h000000, 1'b1);
    checkOutput(1'b0, 0, 24'h000001);

    // Two pairs at once: pair 0 (0x1000) plus tap 90 -> pair 11 (0x100).
    clearTaps();
    taps[0]  = 24'h020000;
    taps[90] = 24'h020000;
    applyStimulus(1'b0, 24'h001100, 1'b1);
    checkOutput(1'b0, 0, 24'h000000);

    // Overrun: second strobe 10 edges into the computation is ignored.
    @(posedge clk);
    #1;
    clearTaps();
    taps[0] = 24'h020000;
    check("overrun_before", 32'(ovMain), 32'd0);
    applyStimulus(1'b0, 24'h001000, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    applyStimulus(1'b0, 24'h000000, 1'b0);
    check("overrun_set", 32'(ovMain), 32'd1);
    checkOutput(1'b0, 10, 24'h001100);
    repeat (60) @(posedge clk);
    #1;
    check("overrun_sticky", 32'(ovMain), 32'd1);
    check("idle_after_overrun", 32'(busyMain), 32'd0);

    // Reset at edge 30 of a computation, with a strobe in the reset cycle.
    applyStimulus(1'b0, 24'h000000, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst    = 1'b0;
    svMain = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    svMain = 1'b0;
    check("midreset_y", 32'(yMain), 32'd0);
    check("midreset_busy", 32'(busyMain), 32'd0);
    check("midreset_overrun", 32'(ovMain), 32'd0);
    repeat (70) @(posedge clk);
    #1;
    check("midreset_still_idle", 32'(busyMain), 32'd0);
    check("midreset_y_after", 32'(yMain), 32'd0);
    applyStimulus(1'b0, 24'h001000, 1'b1);
    checkOutput(1'b0, 0, 24'h000000);

    // Saturation on the all-0x1FFFF coefficient instance.
    @(posedge clk);
    #1;
    setAllTaps(24'h7FFFFF);
    applyStimulus(1'b1, 24'h7FFFFF, 1'b1);
    checkOutput(1'b1, 0, 24'h000000);
    setAllTaps(24'h800000);
    applyStimulus(1'b1, 24'h800000, 1'b1);
    checkOutput(1'b1, 0, 24'h7FFFFF);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(expMainQ.size() + expSatQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
